// File: rtl/daytime_pkg.sv
// Shared types and sizing helpers for the day-time phase scheduler.
package daytime_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2
  } phase_t;

  // A per-direction sum needs enough headroom to add every lane without overflow.
  function automatic int dir_sum_w(input int countW, input int lanesPerDir);
    return countW + $clog2(lanesPerDir) + 1;
  endfunction

endpackage

// File: rtl/daytime_scheduler_if.sv
// Sensor-side and light-side signals of the day-time scheduler, grouped as one bundle.
interface daytime_scheduler_if #(
  parameter int NUM_DIRS      = 4,
  parameter int LANES_PER_DIR = 2,
  parameter int COUNT_W       = 8
);
  localparam int DIR_W = $clog2(NUM_DIRS);
  localparam int LANES = NUM_DIRS * LANES_PER_DIR;

  logic                       en;
  logic [LANES*COUNT_W-1:0]   lane_count;
  logic [LANES-1:0]           green_out;
  logic [LANES-1:0]           yellow_out;
  logic [DIR_W-1:0]           active_dir;
  logic                       phase_done;

  modport master (
    output en, lane_count,
    input  green_out, yellow_out, active_dir, phase_done
  );

  modport slave (
    input  en, lane_count,
    output green_out, yellow_out, active_dir, phase_done
  );
endinterface

// File: rtl/daytime_scheduler_max_dir_select.sv
// Combinational masked argmax over direction sums; ties resolve to the lowest index.
module max_dir_select #(
  parameter int NUM_DIRS = 4,
  parameter int SUM_W    = 10,
  parameter int DIR_W    = $clog2(NUM_DIRS)
) (
  input  logic [NUM_DIRS*SUM_W-1:0] sums,
  input  logic [NUM_DIRS-1:0]       exclude,
  output logic [DIR_W-1:0]          idx,
  output logic                      valid,
  output logic [SUM_W-1:0]          maxVal
);

  // Strict greater-than keeps the earliest direction on ties.
  always_comb begin
    idx    = '0;
    valid  = 1'b0;
    maxVal = '0;
    for (int d = 0; d < NUM_DIRS; d++) begin
      if (!exclude[d] && (!valid || sums[d*SUM_W +: SUM_W] > maxVal)) begin
        idx    = DIR_W'(d);
        valid  = 1'b1;
        maxVal = sums[d*SUM_W +: SUM_W];
      end
    end
  end

endmodule

// File: rtl/daytime_scheduler.sv
// Day-time phase scheduler: grants green to the busiest direction with min/max green
// timing and a yellow plus all-red clearance between grants.
module daytime_scheduler
  import daytime_pkg::*;
#(
  parameter int NUM_DIRS      = 4,
  parameter int LANES_PER_DIR = 2,
  parameter int COUNT_W       = 8,
  parameter int MIN_GREEN     = 4,
  parameter int MAX_GREEN     = 16,
  parameter int YELLOW_TIME   = 2,
  parameter int ALL_RED_TIME  = 1
) (
  input logic                clk,
  input logic                rst_n,
  daytime_scheduler_if.slave bus
);

  localparam int DIR_W   = $clog2(NUM_DIRS);
  localparam int SUM_W   = dir_sum_w(COUNT_W, LANES_PER_DIR);
  localparam int TIMER_W = $clog2(MAX_GREEN + 1);
  localparam int CNT_W   = TIMER_W + 1;
  localparam int LANES   = NUM_DIRS * LANES_PER_DIR;

  phase_t                     state, nxtState;
  logic [TIMER_W-1:0]         timer, nxtTimer;
  logic [DIR_W-1:0]           activeDir, nxtDir;
  logic                       prevValid, nxtPrevValid;
  logic [LANES-1:0]           greenReg, yellowReg, laneMask;
  logic                       doneReg, nxtDone;
  logic [NUM_DIRS*SUM_W-1:0]  sumsFlat;
  logic [SUM_W-1:0]           ownSum, selMax;
  logic [NUM_DIRS-1:0]        excludeMask;
  logic [DIR_W-1:0]           selIdx;
  logic                       selValid;
  logic [CNT_W-1:0]           cyclesInState, nxtCycles;

  always_comb begin
    sumsFlat = '0;
    for (int d = 0; d < NUM_DIRS; d++) begin
      for (int l = 0; l < LANES_PER_DIR; l++) begin
        sumsFlat[d*SUM_W +: SUM_W] = sumsFlat[d*SUM_W +: SUM_W]
          + SUM_W'(bus.lane_count[(d*LANES_PER_DIR+l)*COUNT_W +: COUNT_W]);
      end
    end
  end

  // Outside GREEN/YELLOW activeDir holds the last served direction, so it doubles as prev.
  assign ownSum        = sumsFlat[int'(activeDir)*SUM_W +: SUM_W];
  assign excludeMask   = (state == ALL_RED && !prevValid) ? '0 : (NUM_DIRS'(1) << activeDir);
  assign cyclesInState = {1'b0, timer} + CNT_W'(1);

  max_dir_select #(
    .NUM_DIRS (NUM_DIRS),
    .SUM_W    (SUM_W),
    .DIR_W    (DIR_W)
  ) selector (
    .sums    (sumsFlat),
    .exclude (excludeMask),
    .idx     (selIdx),
    .valid   (selValid),
    .maxVal  (selMax)
  );

  always_comb begin
    nxtState     = state;
    nxtTimer     = (&timer) ? timer : timer + TIMER_W'(1);
    nxtDir       = activeDir;
    nxtPrevValid = prevValid;
    case (state)
      ALL_RED: begin
        if (bus.en && cyclesInState >= CNT_W'(ALL_RED_TIME)) begin
          if (selValid && selMax != '0) begin
            nxtState = GREEN;
            nxtDir   = selIdx;
            nxtTimer = '0;
          end else if (prevValid && ownSum != '0) begin
            nxtState = GREEN;
            nxtTimer = '0;
          end
        end
      end
      GREEN: begin
        if (!bus.en || cyclesInState >= CNT_W'(MAX_GREEN) ||
            (cyclesInState >= CNT_W'(MIN_GREEN) &&
             (ownSum == '0 || (selValid && selMax > ownSum)))) begin
          nxtState = YELLOW;
          nxtTimer = '0;
        end
      end
      YELLOW: begin
        if (cyclesInState >= CNT_W'(YELLOW_TIME)) begin
          nxtState     = ALL_RED;
          nxtTimer     = '0;
          nxtPrevValid = 1'b1;
        end
      end
      default: begin
        nxtState = ALL_RED;
        nxtTimer = '0;
      end
    endcase
  end

  // Lights are decoded from the next state so the registered outputs line up with it.
  always_comb begin
    laneMask = '0;
    for (int d = 0; d < NUM_DIRS; d++) begin
      laneMask[d*LANES_PER_DIR +: LANES_PER_DIR] = {LANES_PER_DIR{nxtDir == DIR_W'(d)}};
    end
    nxtCycles = {1'b0, nxtTimer} + CNT_W'(1);
    nxtDone   = (nxtState == YELLOW) && (nxtCycles == CNT_W'(YELLOW_TIME));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ALL_RED;
      timer     <= '0;
      activeDir <= '0;
      prevValid <= 1'b0;
      greenReg  <= '0;
      yellowReg <= '0;
      doneReg   <= 1'b0;
    end else begin
      state     <= nxtState;
      timer     <= nxtTimer;
      activeDir <= nxtDir;
      prevValid <= nxtPrevValid;
      greenReg  <= (nxtState == GREEN)  ? laneMask : '0;
      yellowReg <= (nxtState == YELLOW) ? laneMask : '0;
      doneReg   <= nxtDone;
    end
  end

  assign bus.green_out  = greenReg;
  assign bus.yellow_out = yellowReg;
  assign bus.active_dir = activeDir;
  assign bus.phase_done = doneReg;

endmodule

// File: tb/tb_daytime_scheduler.sv
// Directed bench for daytime_scheduler at default parameters: grant, tie/exclusion,
// max green, preemption, enable drop and mid-yellow reset.
module tb_daytime_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  daytime_scheduler_if #(.NUM_DIRS(4), .LANES_PER_DIR(2), .COUNT_W(8)) bus ();

  daytime_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] GN = 8'h03, GE = 8'h0C, GS = 8'h30, GW = 8'hC0;

  // Lane counts in N0,N1,E0,E1,S0,S1,W0,W1 order, packed lane 0 at the LSB.
  function automatic logic [63:0] mk(input logic [7:0] n0, n1, e0, e1, s0, s1, w0, w1);
    return {w1, w0, s1, s0, e1, e0, n1, n0};
  endfunction

  task automatic applyStimulus(input logic r, input logic e, input logic [63:0] c);
    rst_n          = r;
    bus.en         = e;
    bus.lane_count = c;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expGreen,
                             input logic [7:0] expYellow, input logic [1:0] expDir,
                             input logic expDone);
    checks++;
    assert (bus.green_out === expGreen) else begin
      errors++;
      $error("[TB] FAIL %s green_out observed %b expected %b", tag, bus.green_out, expGreen);
    end
    checks++;
    assert (bus.yellow_out === expYellow) else begin
      errors++;
      $error("[TB] FAIL %s yellow_out observed %b expected %b", tag, bus.yellow_out, expYellow);
    end
    checks++;
    assert (bus.active_dir === expDir) else begin
      errors++;
      $error("[TB] FAIL %s active_dir observed %0d expected %0d", tag, bus.active_dir, expDir);
    end
    checks++;
    assert (bus.phase_done === expDone) else begin
      errors++;
      $error("[TB] FAIL %s phase_done observed %b expected %b", tag, bus.phase_done, expDone);
    end
  endtask

  task automatic stepCheck(input string tag, input logic [7:0] g, input logic [7:0] y,
                           input logic [1:0] d, input logic done);
    @(posedge clk);
    #1;
    checkOutput(tag, g, y, d, done);
  endtask

  task automatic runGreen(input string tag, input logic [7:0] g, input logic [1:0] d, input int n);
    for (int i = 0; i < n; i++) stepCheck(tag, g, 8'h00, d, 1'b0);
  endtask

  task automatic yellowRed(input string tag, input logic [7:0] m, input logic [1:0] d);
    stepCheck({tag, "_y1"}, 8'h00, m, d, 1'b0);
    stepCheck({tag, "_y2"}, 8'h00, m, d, 1'b1);
    stepCheck({tag, "_red"}, 8'h00, 8'h00, d, 1'b0);
  endtask

  initial begin
    // Reset held three cycles with traffic present.
    applyStimulus(1'b0, 1'b1, mk(10, 10, 0, 0, 0, 0, 0, 0));
    repeat (3) stepCheck("reset", 8'h00, 8'h00, 2'd0, 1'b0);

    // First grant to N; nobody exceeds 20 so it runs to MAX_GREEN, then N is re-taken.
    applyStimulus(1'b1, 1'b1, mk(10, 10, 0, 0, 0, 0, 0, 0));
    stepCheck("grantN", GN, 8'h00, 2'd0, 1'b0);
    runGreen("holdN", GN, 2'd0, 15);
    yellowRed("clearN", GN, 2'd0);
    stepCheck("regrantN", GN, 8'h00, 2'd0, 1'b0);

    // Enable dropped on N's first green cycle: yellow next, then all-red held.
    applyStimulus(1'b1, 1'b0, mk(10, 10, 0, 0, 0, 0, 0, 0));
    stepCheck("enOff_y1", 8'h00, GN, 2'd0, 1'b0);
    stepCheck("enOff_y2", 8'h00, GN, 2'd0, 1'b1);
    repeat (4) stepCheck("enOffHold", 8'h00, 8'h00, 2'd0, 1'b0);

    // E and S tie at 20: E wins, then S because E is excluded.
    applyStimulus(1'b1, 1'b1, mk(0, 0, 10, 10, 10, 10, 0, 0));
    stepCheck("tieE", GE, 8'h00, 2'd1, 1'b0);
    runGreen("holdE", GE, 2'd1, 15);
    yellowRed("clearE", GE, 2'd1);
    stepCheck("exclS", GS, 8'h00, 2'd2, 1'b0);

    // S empties: leaves at MIN_GREEN. N=200 runs to max, E=1 preempted at min.
    applyStimulus(1'b1, 1'b1, mk(100, 100, 1, 0, 0, 0, 0, 0));
    runGreen("minS", GS, 2'd2, 3);
    yellowRed("clearS", GS, 2'd2);
    stepCheck("maxN", GN, 8'h00, 2'd0, 1'b0);
    runGreen("maxN", GN, 2'd0, 15);
    yellowRed("clearMaxN", GN, 2'd0);
    stepCheck("minE", GE, 8'h00, 2'd1, 1'b0);
    runGreen("minE", GE, 2'd1, 3);
    yellowRed("clearMinE", GE, 2'd1);
    stepCheck("backN", GN, 8'h00, 2'd0, 1'b0);

    // N at 30, W jumps to 50 on green cycle 2: yellow arrives on cycle 5.
    applyStimulus(1'b1, 1'b1, mk(15, 15, 0, 0, 0, 0, 0, 0));
    stepCheck("preN2", GN, 8'h00, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, mk(15, 15, 0, 0, 0, 0, 25, 25));
    runGreen("preN34", GN, 2'd0, 2);
    yellowRed("clearPreN", GN, 2'd0);
    stepCheck("grantW", GW, 8'h00, 2'd3, 1'b0);

    // Reset during W's yellow clears every light immediately.
    applyStimulus(1'b1, 1'b0, mk(15, 15, 0, 0, 0, 0, 25, 25));
    stepCheck("wY1", 8'h00, GW, 2'd3, 1'b0);
    applyStimulus(1'b0, 1'b1, mk(15, 15, 0, 0, 0, 0, 25, 25));
    stepCheck("rstInY", 8'h00, 8'h00, 2'd0, 1'b0);
    stepCheck("rstHold", 8'h00, 8'h00, 2'd0, 1'b0);

    // No traffic and no history: stay all-red; then W wins with nothing excluded.
    applyStimulus(1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) stepCheck("idleZero", 8'h00, 8'h00, 2'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, mk(15, 15, 0, 0, 0, 0, 25, 25));
    stepCheck("postRstW", GW, 8'h00, 2'd3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
